pipelined_addsub: RTL and testbench

- Parametrised, pipelined successor to the team's 64-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands across STAGES register stages. Each stage resolves one WIDTH/STAGES-bit chunk, and the carry is passed between stages.
- Has a valid/ready handshake with backpressure, and produces ARM-style N/Z/C/V flags.
- Sits between the ALU operand latches and writeback in the pipelined CPU datapath.

---
 rtl/pipelined_addsub.sv | 123 ++++++++++++
 tb/tb_pipelined_addsub.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one CW-bit chunk per stage, carry chained
// between stages, valid/ready handshake with global stall, ARM-style N/Z/C/V flags.
module pipelined_addsub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);
    localparam int CW = WIDTH / STAGES;

    logic valid_q [STAGES];
    logic carry_q [STAGES];
    logic stall;

    assign stall     = valid_q[STAGES-1] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = valid_q[STAGES-1];

    for (genvar gi = 0; gi < STAGES; gi++) begin : gen_stage
        // Stage gi sees the operand bits from chunk gi upward and the result bits below it.
        localparam int UPW = WIDTH - gi * CW;
        localparam int RW  = gi * CW + CW;

        logic [UPW-1:0] a_i;
        logic [UPW-1:0] b_i;
        logic           c_i;
        logic           v_i;
        logic [CW:0]    chunk_sum;
        logic [RW-1:0]  res_next;
        logic [RW-1:0]  res_reg;
        logic           valid_reg;
        logic           carry_reg;

        if (gi == 0) begin : gen_head
            // Subtraction as A + ~B + 1: sub both inverts B and is the chunk-0 carry-in.
            assign a_i      = A;
            assign b_i      = sub ? ~B : B;
            assign c_i      = sub;
            assign v_i      = in_valid;
            assign res_next = chunk_sum[CW-1:0];
        end else begin : gen_body
            assign a_i      = gen_stage[gi-1].gen_fwd.a_reg;
            assign b_i      = gen_stage[gi-1].gen_fwd.b_reg;
            assign c_i      = carry_q[gi-1];
            assign v_i      = valid_q[gi-1];
            assign res_next = {chunk_sum[CW-1:0], gen_stage[gi-1].res_reg};
        end

        assign chunk_sum = {1'b0, a_i[CW-1:0]} + {1'b0, b_i[CW-1:0]} + {{CW{1'b0}}, c_i};

        // Empty stages still advance, but only a valid op overwrites the data.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                valid_reg <= 1'b0;
                carry_reg <= 1'b0;
                res_reg   <= '0;
            end else if (!stall) begin
                valid_reg <= v_i;
                if (v_i) begin
                    carry_reg <= chunk_sum[CW];
                    res_reg   <= res_next;
                end
            end
        end

        assign valid_q[gi] = valid_reg;
        assign carry_q[gi] = carry_reg;

        if (gi < STAGES - 1) begin : gen_fwd
            logic [UPW-CW-1:0] a_reg;
            logic [UPW-CW-1:0] b_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    a_reg <= '0;
                    b_reg <= '0;
                end else if (!stall && v_i) begin
                    a_reg <= a_i[UPW-1:CW];
                    b_reg <= b_i[UPW-1:CW];
                end
            end
        end else begin : gen_last
            logic flag_n_reg;
            logic flag_z_reg;
            logic flag_v_reg;
            logic ovf_next;

            // Overflow: operands (with B already inverted) agree in sign, result does not.
            assign ovf_next = (a_i[UPW-1] == b_i[UPW-1]) && (res_next[RW-1] != a_i[UPW-1]);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    flag_n_reg <= 1'b0;
                    flag_z_reg <= 1'b0;
                    flag_v_reg <= 1'b0;
                end else if (!stall && v_i) begin
                    flag_n_reg <= res_next[RW-1];
                    flag_z_reg <= (res_next == '0);
                    flag_v_reg <= ovf_next;
                end
            end

            assign result = res_reg;
            assign flag_n = flag_n_reg;
            assign flag_z = flag_z_reg;
            assign flag_c = carry_reg;
            assign flag_v = flag_v_reg;
        end
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub in three configurations: 64/4, 64/1 and 32/8.
`timescale 1ns/1ps
module tb_pipelined_addsub;
    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        s;
        logic [63:0] r;
        logic        n;
        logic        z;
        logic        c;
        logic        v;
    } op_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic        iv0, ir0, sub0, ov0, or0, n0, z0, c0, v0;
    logic [63:0] a0, b0, r0;
    logic        iv1, ir1, sub1, ov1, or1, n1, z1, c1, v1;
    logic [63:0] a1, b1, r1;
    logic        iv2, ir2, sub2, ov2, or2, n2, z2, c2, v2;
    logic [31:0] a2, b2, r2;

    pipelined_addsub #(.WIDTH(64), .STAGES(4)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv0), .in_ready(ir0), .A(a0), .B(b0),
        .sub(sub0), .out_valid(ov0), .out_ready(or0), .result(r0),
        .flag_n(n0), .flag_z(z0), .flag_c(c0), .flag_v(v0));

    pipelined_addsub #(.WIDTH(64), .STAGES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
        .sub(sub1), .out_valid(ov1), .out_ready(or1), .result(r1),
        .flag_n(n1), .flag_z(z1), .flag_c(c1), .flag_v(v1));

    pipelined_addsub #(.WIDTH(32), .STAGES(8)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv2), .in_ready(ir2), .A(a2), .B(b2),
        .sub(sub2), .out_valid(ov2), .out_ready(or2), .result(r2),
        .flag_n(n2), .flag_z(z2), .flag_c(c2), .flag_v(v2));

    int checks = 0;
    int errors = 0;
    op_t q0[$];
    op_t q1[$];
    op_t q2[$];
    op_t tbl64[5];
    op_t tbl32[5];

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (ov0 !== 1'b0 || r0 !== 64'd0) begin
            errors++;
            $display("FAIL reset_out: out_valid=%b result=%0h required 0/0", ov0, r0);
        end
        checks++;
        if ({n0, z0, c0, v0} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: nzcv=%b required 0000", {n0, z0, c0, v0});
        end
        checks++;
        if (ir0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", ir0);
        end
        checks++;
        if (ov1 !== 1'b0 || ov2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_aux_valid: got %b%b required 00", ov1, ov2);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (ov0 !== 1'b0 || ir0 !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle: out_valid=%b in_ready=%b required 0/1", ov0, ir0);
        end
    endtask

    task automatic test_addsub_s4();
        for (int i = 0; i < 5; i++) begin
            op_t e;
            int  lat;
            @(negedge clk);
            a0 = tbl64[i].a; b0 = tbl64[i].b; sub0 = tbl64[i].s; iv0 = 1'b1;
            #1;
            checks++;
            if (ir0 !== 1'b1) begin
                errors++;
                $display("FAIL s4_accept[%0d]: in_ready=%b required 1", i, ir0);
            end
            q0.push_back(tbl64[i]);
            lat = 0;
            do begin
                @(negedge clk);
                iv0 = 1'b0;
                lat++;
                #1;
            end while (!ov0 && lat < 20);
            checks++;
            if (lat !== 4) begin
                errors++;
                $display("FAIL s4_latency[%0d]: got %0d required 4", i, lat);
            end
            if (ov0 && q0.size() > 0) begin
                e = q0.pop_front();
                checks++;
                if ({r0, n0, z0, c0, v0} !== {e.r, e.n, e.z, e.c, e.v}) begin
                    errors++;
                    $display("FAIL s4_op[%0d]: result=%h nzcv=%b required %h %b",
                             i, r0, {n0, z0, c0, v0}, e.r, {e.n, e.z, e.c, e.v});
                end
            end
        end
        q0.delete();
    endtask

    task automatic test_back_to_back_stall();
        int  idx = 0;
        int  got = 0;
        bit  extra = 1'b0;
        op_t e;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(negedge clk);
            or0 = !(cyc >= 6 && cyc <= 8);
            if (idx < 8) begin
                iv0 = 1'b1; a0 = 64'(idx); b0 = 64'd40; sub0 = 1'b0;
            end else begin
                iv0 = 1'b0;
            end
            #1;
            if (ov0 && !or0) begin
                checks++;
                if (ir0 !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready cyc %0d: got %b required 0", cyc, ir0);
                end
            end
            if (ov0 && or0) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL stream_unexpected cyc %0d: result=%0d required no output", cyc, r0);
                end else begin
                    e = q0.pop_front();
                    if ({r0, n0, z0, c0, v0} !== {e.r, e.n, e.z, e.c, e.v}) begin
                        errors++;
                        $display("FAIL stream_op[%0d]: result=%0d nzcv=%b required %0d %b",
                                 got, r0, {n0, z0, c0, v0}, e.r, {e.n, e.z, e.c, e.v});
                    end
                end
                got++;
            end
            if (iv0 && ir0) begin
                e = '{a: 64'(idx), b: 64'd40, s: 1'b0, r: 64'(idx + 40),
                      n: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0};
                q0.push_back(e);
                idx++;
            end
        end
        checks++;
        if (got !== 8) begin
            errors++;
            $display("FAIL stream_count: got %0d results required 8", got);
        end
        iv0 = 1'b0;
        or0 = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (ov0) extra = 1'b1;
        end
        checks++;
        if (extra !== 1'b0 || q0.size() != 0) begin
            errors++;
            $display("FAIL stream_tail: extra=%b pending=%0d required 0/0", extra, q0.size());
        end
        q0.delete();
    endtask

    task automatic test_reset_flight();
        bit  stale = 1'b0;
        int  lat;
        or0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            iv0 = 1'b1; a0 = 64'(100 + k); b0 = 64'd0; sub0 = 1'b0;
        end
        @(negedge clk);
        iv0 = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (ov0 !== 1'b1) begin
            errors++;
            $display("FAIL flight_precond: out_valid=%b required 1", ov0);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (ov0 !== 1'b0 || r0 !== 64'd0 || {n0, z0, c0, v0} !== 4'b0000) begin
            errors++;
            $display("FAIL flight_async_clear: out_valid=%b result=%0h nzcv=%b required 0/0/0000",
                     ov0, r0, {n0, z0, c0, v0});
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (ov0) stale = 1'b1;
        end
        checks++;
        if (stale !== 1'b0) begin
            errors++;
            $display("FAIL flight_stale: stale output seen=%b required 0", stale);
        end
        @(negedge clk);
        a0 = 64'd1; b0 = 64'd2; sub0 = 1'b0; iv0 = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            iv0 = 1'b0;
            lat++;
            #1;
        end while (!ov0 && lat < 20);
        checks++;
        if (lat !== 4 || r0 !== 64'd3) begin
            errors++;
            $display("FAIL flight_recover: latency=%0d result=%0d required 4/3", lat, r0);
        end
    endtask

    task automatic test_addsub_s1();
        for (int i = 0; i < 5; i++) begin
            op_t e;
            int  lat;
            @(negedge clk);
            a1 = tbl64[i].a; b1 = tbl64[i].b; sub1 = tbl64[i].s; iv1 = 1'b1;
            #1;
            if (ir1) q1.push_back(tbl64[i]);
            lat = 0;
            do begin
                @(negedge clk);
                iv1 = 1'b0;
                lat++;
                #1;
            end while (!ov1 && lat < 20);
            checks++;
            if (lat !== 1) begin
                errors++;
                $display("FAIL s1_latency[%0d]: got %0d required 1", i, lat);
            end
            if (ov1 && q1.size() > 0) begin
                e = q1.pop_front();
                checks++;
                if ({r1, n1, z1, c1, v1} !== {e.r, e.n, e.z, e.c, e.v}) begin
                    errors++;
                    $display("FAIL s1_op[%0d]: result=%h nzcv=%b required %h %b",
                             i, r1, {n1, z1, c1, v1}, e.r, {e.n, e.z, e.c, e.v});
                end
            end
        end
        q1.delete();
    endtask

    task automatic test_addsub_w32();
        for (int i = 0; i < 5; i++) begin
            op_t         e;
            int          lat;
            logic [63:0] ta;
            logic [63:0] tb;
            ta = tbl32[i].a;
            tb = tbl32[i].b;
            @(negedge clk);
            a2 = ta[31:0]; b2 = tb[31:0]; sub2 = tbl32[i].s; iv2 = 1'b1;
            #1;
            if (ir2) q2.push_back(tbl32[i]);
            lat = 0;
            do begin
                @(negedge clk);
                iv2 = 1'b0;
                lat++;
                #1;
            end while (!ov2 && lat < 30);
            checks++;
            if (lat !== 8) begin
                errors++;
                $display("FAIL w32_latency[%0d]: got %0d required 8", i, lat);
            end
            if (ov2 && q2.size() > 0) begin
                e = q2.pop_front();
                checks++;
                if ({32'd0, r2, n2, z2, c2, v2} !== {e.r, e.n, e.z, e.c, e.v}) begin
                    errors++;
                    $display("FAIL w32_op[%0d]: result=%h nzcv=%b required %h %b",
                             i, r2, {n2, z2, c2, v2}, e.r, {e.n, e.z, e.c, e.v});
                end
            end
        end
        q2.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        iv0 = 1'b0; a0 = '0; b0 = '0; sub0 = 1'b0; or0 = 1'b1;
        iv1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0; or1 = 1'b1;
        iv2 = 1'b0; a2 = '0; b2 = '0; sub2 = 1'b0; or2 = 1'b1;

        tbl64[0] = '{a: 64'd10, b: 64'd20, s: 1'b0, r: 64'd30,
                     n: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0};
        tbl64[1] = '{a: 64'd5, b: 64'd7, s: 1'b1, r: 64'hFFFF_FFFF_FFFF_FFFE,
                     n: 1'b1, z: 1'b0, c: 1'b0, v: 1'b0};
        tbl64[2] = '{a: 64'd7, b: 64'd7, s: 1'b1, r: 64'd0,
                     n: 1'b0, z: 1'b1, c: 1'b1, v: 1'b0};
        tbl64[3] = '{a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'd1, s: 1'b0, r: 64'h8000_0000_0000_0000,
                     n: 1'b1, z: 1'b0, c: 1'b0, v: 1'b1};
        tbl64[4] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd1, s: 1'b0, r: 64'd0,
                     n: 1'b0, z: 1'b1, c: 1'b1, v: 1'b0};

        tbl32[0] = '{a: 64'd10, b: 64'd20, s: 1'b0, r: 64'd30,
                     n: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0};
        tbl32[1] = '{a: 64'd5, b: 64'd7, s: 1'b1, r: 64'h0000_0000_FFFF_FFFE,
                     n: 1'b1, z: 1'b0, c: 1'b0, v: 1'b0};
        tbl32[2] = '{a: 64'd7, b: 64'd7, s: 1'b1, r: 64'd0,
                     n: 1'b0, z: 1'b1, c: 1'b1, v: 1'b0};
        tbl32[3] = '{a: 64'h7FFF_FFFF, b: 64'd1, s: 1'b0, r: 64'h8000_0000,
                     n: 1'b1, z: 1'b0, c: 1'b0, v: 1'b1};
        tbl32[4] = '{a: 64'hFFFF_FFFF, b: 64'd1, s: 1'b0, r: 64'd0,
                     n: 1'b0, z: 1'b1, c: 1'b1, v: 1'b0};

        test_reset();
        test_addsub_s4();
        test_back_to_back_stall();
        test_reset_flight();
        test_addsub_s1();
        test_addsub_w32();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
